// File: rtl/stream_store_unit.sv
`default_nettype none
// ============================================================================
// stream_store_unit
//   Unpacks GVECT-lane stream beats into sequential single-word memory writes
//   for NWI work instances of SIZE words each.
//   Revision: 1.0
// ============================================================================
module stream_store_unit #(
   parameter int DATAW = 32,
   parameter int GVECT = 2,
   parameter int SIZE  = 1024,
   parameter int NWI   = 1,
   parameter int ADDRW = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   s_tvalid,
   input  logic [DATAW*GVECT-1:0] s_tdata,
   output logic                   s_tready,
   output logic                   mem_we,
   output logic [ADDRW-1:0]       mem_addr,
   output logic [DATAW-1:0]       mem_wdata,
   input  logic                   mem_wready,
   output logic                   done,
   output logic [31:0]            wi_count
);

   localparam int               c_LANEW     = (GVECT > 1) ? $clog2(GVECT) : 1;
   localparam logic [c_LANEW-1:0] c_LAST_LANE = c_LANEW'(GVECT - 1);
   localparam logic [ADDRW-1:0] c_LAST_ADDR = ADDRW'(SIZE - 1);
   localparam logic [31:0]      c_LAST_WI   = 32'(NWI - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [DATAW-1:0]     r_buf [GVECT];
   logic                 r_valid;
   logic [c_LANEW-1:0]   r_lane;
   logic [ADDRW-1:0]     r_addr;
   logic [31:0]          r_wi;

   logic                 w_run;
   logic                 w_wr;
   logic                 w_last_lane;
   logic                 w_last_addr;
   logic                 w_final;
   logic                 w_ready;
   logic                 w_acc;
   logic                 w_start;

   assign w_run       = (r_state == S_RUN);
   assign w_wr        = w_run && r_valid && mem_wready;
   assign w_last_lane = (r_lane == c_LAST_LANE);
   assign w_last_addr = (r_addr == c_LAST_ADDR);
   assign w_final     = w_wr && w_last_addr && (r_wi == c_LAST_WI);

   // A new beat may land in the same cycle the last lane drains, except on the
   // final write of the run, so nothing is left buffered in DONE.
   assign w_ready = w_run && (!r_valid || (w_last_lane && w_wr && !w_final));
   assign w_acc   = s_tvalid && w_ready;
   assign w_start = start && (r_state != S_RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_final) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_lane  <= '0;
         r_addr  <= '0;
         r_wi    <= '0;
         for (int k = 0; k < GVECT; k++) begin
            r_buf[k] <= '0;
         end
      end else if (w_start) begin
         r_valid <= 1'b0;
         r_lane  <= '0;
         r_addr  <= '0;
         r_wi    <= '0;
      end else begin
         if (w_wr) begin
            if (w_last_addr) begin
               r_addr <= '0;
               r_wi   <= r_wi + 32'd1;
            end else begin
               r_addr <= r_addr + ADDRW'(1);
            end
            if (w_last_lane) begin
               r_lane  <= '0;
               r_valid <= 1'b0;
            end else begin
               r_lane <= r_lane + c_LANEW'(1);
            end
         end
         // Accept overrides the drain above when both happen together.
         if (w_acc) begin
            r_valid <= 1'b1;
            r_lane  <= '0;
            for (int k = 0; k < GVECT; k++) begin
               r_buf[k] <= s_tdata[k*DATAW +: DATAW];
            end
         end
      end
   end

   assign s_tready  = w_ready;
   assign mem_we    = r_valid;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_buf[r_lane];
   assign done      = (r_state == S_DONE);
   assign wi_count  = r_wi;

endmodule
`default_nettype wire

// File: tb/tb_stream_store_unit.sv
`default_nettype none
// ============================================================================
// tb_stream_store_unit
//   Table-driven and hand-sequenced checks of stream_store_unit against a
//   queue-based reference model (NWI=1 and NWI=2 instances).
//   Revision: 1.0
// ============================================================================
module tb_stream_store_unit;

   localparam int DATAW = 32;
   localparam int GVECT = 2;
   localparam int SIZE  = 1024;
   localparam int ADDRW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst_n, start, s_tvalid, mem_wready;
   logic [DATAW*GVECT-1:0] s_tdata;

   logic             rdy1, we1, done1, rdy2, we2, done2;
   logic [ADDRW-1:0] addr1, addr2;
   logic [DATAW-1:0] wd1, wd2;
   logic [31:0]      wi1, wi2;

   stream_store_unit #(.DATAW(DATAW), .GVECT(GVECT), .SIZE(SIZE), .NWI(1), .ADDRW(ADDRW)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
      .s_tready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
      .mem_wready(mem_wready), .done(done1), .wi_count(wi1));

   stream_store_unit #(.DATAW(DATAW), .GVECT(GVECT), .SIZE(SIZE), .NWI(2), .ADDRW(ADDRW)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
      .s_tready(rdy2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2),
      .mem_wready(mem_wready), .done(done2), .wi_count(wi2));

   // selected DUT view
   logic             sel;
   logic             t_rdy, t_we, t_done;
   logic [ADDRW-1:0] t_addr;
   logic [DATAW-1:0] t_wd;
   logic [31:0]      t_wi;
   always_comb begin
      t_rdy  = sel ? rdy2  : rdy1;
      t_we   = sel ? we2   : we1;
      t_done = sel ? done2 : done1;
      t_addr = sel ? addr2 : addr1;
      t_wd   = sel ? wd2   : wd1;
      t_wi   = sel ? wi2   : wi1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit               chk_en = 1'b0;
   bit               running = 1'b0;
   bit               done_m  = 1'b0;
   int               nwr = 0;
   int               nwi_m = 1;
   int               bk = 0;
   logic [DATAW-1:0] q[$];
   logic [DATAW-1:0] mem [SIZE];

   bit                     ev_rst = 1'b1, ev_acc = 1'b0, ev_wr = 1'b0, ev_start = 1'b0;
   logic [DATAW*GVECT-1:0] ev_data;
   logic [ADDRW-1:0]       ev_addr;
   logic [DATAW-1:0]       ev_wd;
   bit                     exp_rdy;

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         exp_rdy = running && (q.size() == 0 ||
                   (q.size() == 1 && mem_wready && (nwr + 1 != SIZE * nwi_m)));
         chk("s_tready", t_rdy, exp_rdy);
         chk("mem_we", t_we, q.size() != 0);
         chk("done", t_done, done_m);
         chk("wi_count", t_wi, nwr / SIZE);
         if (t_we && mem_wready) begin
            chk("mem_addr", t_addr, nwr % SIZE);
            if (q.size() > 0) chk("mem_wdata", t_wd, q[0]);
         end
      end
      ev_rst   = !rst_n;
      ev_acc   = t_rdy && s_tvalid;
      ev_wr    = t_we && mem_wready;
      ev_start = start;
      ev_data  = s_tdata;
      ev_addr  = t_addr;
      ev_wd    = t_wd;
   end

   always @(posedge clk) begin
      bit was_running;
      was_running = running;
      if (ev_rst) begin
         running = 1'b0;
         done_m  = 1'b0;
         nwr     = 0;
         q.delete();
      end else begin
         if (ev_wr) begin
            mem[ev_addr] = ev_wd;
            if (q.size() > 0) void'(q.pop_front());
            nwr++;
            if (nwr == SIZE * nwi_m) begin
               running = 1'b0;
               done_m  = 1'b1;
            end
         end
         if (ev_acc) begin
            for (int j = 0; j < GVECT; j++) q.push_back(ev_data[j*DATAW +: DATAW]);
            bk++;
         end
         if (ev_start && !was_running) begin
            running = 1'b1;
            done_m  = 1'b0;
            nwr     = 0;
            bk      = 0;
            q.delete();
         end
      end
   end

   // ---------------- stimulus ----------------
   int gap = 0;
   int wmode = 0;
   int stall_cnt = 0;

   function automatic logic [DATAW*GVECT-1:0] beat(input int k);
      logic [DATAW*GVECT-1:0] r;
      for (int j = 0; j < GVECT; j++) r[j*DATAW +: DATAW] = DATAW'(GVECT * k + j + 1);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      start    = 1'b0;
      s_tvalid = ($urandom_range(99) >= gap);
      s_tdata  = s_tvalid ? beat(bk) : {$urandom, $urandom};
      case (wmode)
         0: mem_wready = 1'b1;
         1: begin
            if (t_we && t_addr == 11 && stall_cnt < 3) begin
               mem_wready = 1'b0;
               stall_cnt++;
            end else begin
               mem_wready = 1'b1;
            end
         end
         default: mem_wready = ($urandom_range(99) < 70);
      endcase
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic clear_mem();
      for (int n = 0; n < SIZE; n++) mem[n] = '0;
   endtask

   task automatic run_to_done(input string name);
      int n = 0;
      while (!done_m && n < 20000) begin
         step();
         n++;
      end
      chk({name, "_timeout"}, done_m, 1'b1);
   endtask

   task automatic check_mem(input string name, input int base);
      int bad = 0;
      for (int n = 0; n < SIZE; n++) if (mem[n] !== DATAW'(base + n + 1)) bad++;
      chk({name, "_mem_bad_words"}, bad, 0);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_s_tready"}, t_rdy, 0);
      chk({name, "_mem_we"}, t_we, 0);
      chk({name, "_mem_addr"}, t_addr, 0);
      chk({name, "_mem_wdata"}, t_wd, 0);
      chk({name, "_done"}, t_done, 0);
      chk({name, "_wi_count"}, t_wi, 0);
   endtask

   typedef struct {
      string name;
      bit    dut;
      int    gap;
      int    wmode;
      int    exp_writes;
      int    exp_wi;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{"plain",      1'b0, 0,  0, 1024, 1};
      tbl[1] = '{"stall11",    1'b0, 0,  1, 1024, 1};
      tbl[2] = '{"gaps",       1'b0, 10, 0, 1024, 1};
      tbl[3] = '{"nwi2",       1'b1, 0,  0, 2048, 2};
      tbl[4] = '{"nwi2_rand",  1'b1, 10, 2, 2048, 2};

      rst_n = 1'b0; start = 1'b0; s_tvalid = 1'b0; s_tdata = '0; mem_wready = 1'b1; sel = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) step();   // beats offered in IDLE must not be taken

      for (int i = 0; i < 5; i++) begin
         sel   = tbl[i].dut;
         nwi_m = tbl[i].dut ? 2 : 1;
         gap   = tbl[i].gap;
         wmode = tbl[i].wmode;
         stall_cnt = 0;
         do_reset();
         clear_mem();
         start = 1'b1;
         step();
         run_to_done(tbl[i].name);
         repeat (4) step();
         @(negedge clk);
         chk({tbl[i].name, "_done"}, t_done, 1'b1);
         chk({tbl[i].name, "_writes"}, nwr, tbl[i].exp_writes);
         chk({tbl[i].name, "_wi_final"}, t_wi, tbl[i].exp_wi);
         check_mem(tbl[i].name, (tbl[i].exp_wi - 1) * SIZE);
         if (wmode == 1) chk("stall_cycles", stall_cnt, 3);
      end

      // start while running is ignored; start in DONE restarts
      sel = 1'b0; nwi_m = 1; gap = 0; wmode = 0;
      do_reset();
      start = 1'b1;
      step();
      begin
         int n = 0;
         while (nwr < 300 && n < 5000) begin
            step();
            n++;
         end
      end
      chk("pre_start_addr", t_addr, 300);
      start = 1'b1;
      step();
      @(negedge clk);
      chk("start_in_run_addr", t_addr, 301);
      chk("start_in_run_done", t_done, 0);
      run_to_done("restart");
      step();
      start = 1'b1;
      step();
      @(negedge clk);
      chk("start_in_done_done", t_done, 0);
      chk("start_in_done_wi", t_wi, 0);
      chk("start_in_done_addr", t_addr, 0);
      repeat (5) step();

      // reset in the middle of a run
      do_reset();
      start = 1'b1;
      step();
      begin
         int n = 0;
         while (nwr < 100 && n < 5000) begin
            step();
            n++;
         end
      end
      rst_n = 1'b0;
      step();
      @(negedge clk);
      check_reset_outputs("midrun_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      clear_mem();
      start = 1'b1;
      step();
      @(negedge clk);
      chk("after_reset_first_addr", t_addr, 0);
      run_to_done("after_reset");
      check_mem("after_reset", 0);
      chk("after_reset_wi", t_wi, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
